// File: rtl/alu_operand_issue_if.sv
// rtl/alu_operand_issue_if.sv - instruction, operand-bundle and writeback signals of the ALU operand issue stage
interface alu_operand_issue_if #(
  parameter int DATA_W = 32
);
  // Decoded instruction stream from upstream
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;

  // Operand bundle towards the ALU
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_i1;
  logic [DATA_W-1:0] out_i2;
  logic [4:0]        out_sel;
  logic [4:0]        out_rd;

  // Result writeback from the downstream result stage
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Driver side: upstream decoder, ALU stage and result stage
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_i1, out_i2, out_sel, out_rd
  );

  // Issue stage side
  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_i1, out_i2, out_sel, out_rd
  );
endinterface

// File: rtl/alu_operand_issue.sv
// rtl/alu_operand_issue.sv - register-file read, pending scoreboard and operand register feeding the ALU (optional RF_BYPASS_EN forwarding)
module alu_operand_issue #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_operand_issue_if.slave bus
);

  // Instruction fields
  logic [4:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic              imm_sel;
  logic [10:0]       imm11;
  logic [DATA_W-1:0] imm_ext;

  assign op      = bus.in_instr[31:27];
  assign rd      = bus.in_instr[26:22];
  assign rs      = bus.in_instr[21:17];
  assign rt      = bus.in_instr[16:12];
  assign imm_sel = bus.in_instr[11];
  assign imm11   = bus.in_instr[10:0];
  assign imm_ext = {{(DATA_W-11){imm11[10]}}, imm11};

  // Architectural state
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic [NREGS-1:0]  pend_d;

  // Operand output register
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_i1_q, out_i1_d;
  logic [DATA_W-1:0] out_i2_q, out_i2_d;
  logic [4:0]        out_sel_q, out_sel_d;
  logic [4:0]        out_rd_q, out_rd_d;

  // Handshake and hazard terms
  logic [NREGS-1:0]  wb_clr_mask;
  logic [NREGS-1:0]  pend_next;
  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // One-hot of the register being written back this cycle; r0 is never tracked
  always_comb begin
    wb_clr_mask = '0;
    if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      wb_clr_mask[bus.wb_addr] = 1'b1;
    end
  end

`ifdef RF_BYPASS_EN
  // A writeback landing this cycle already satisfies a waiting reader
  assign pend_next = pend_q & ~wb_clr_mask;
`else
  // Without forwarding the reader waits until the write is visible in the file
  assign pend_next = pend_q;
`endif

  assign hazard   = bus.in_valid & (pend_next[rs] | (~imm_sel & pend_next[rt]));
  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard;
  assign accept   = bus.in_valid & in_ready;

  // rs read port; r0 is hardwired to zero
  always_comb begin
    rs_val = '0;
    if (rs != 5'd0) begin
      rs_val = regs_q[rs];
`ifdef RF_BYPASS_EN
      if (bus.wb_en && (bus.wb_addr == rs)) begin
        rs_val = bus.wb_data;
      end
`endif
    end
  end

  // rt read port; r0 is hardwired to zero
  always_comb begin
    rt_val = '0;
    if (rt != 5'd0) begin
      rt_val = regs_q[rt];
`ifdef RF_BYPASS_EN
      if (bus.wb_en && (bus.wb_addr == rt)) begin
        rt_val = bus.wb_data;
      end
`endif
    end
  end

  // Register file write: writebacks to r0 are dropped
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      regs_d[bus.wb_addr] = bus.wb_data;
    end
  end

  // Scoreboard: writeback clears, accepted writer sets, set wins on collision
  always_comb begin
    pend_d = pend_q & ~wb_clr_mask;
    if (accept && (rd != 5'd0)) begin
      pend_d[rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Operand register: load on accept, drop valid on drain, otherwise hold
  always_comb begin
    out_valid_d = out_valid_q;
    out_i1_d    = out_i1_q;
    out_i2_d    = out_i2_q;
    out_sel_d   = out_sel_q;
    out_rd_d    = out_rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_i1_d    = rs_val;
      out_i2_d    = imm_sel ? imm_ext : rt_val;
      out_sel_d   = op;
      out_rd_d    = rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_i1_q    <= '0;
      out_i2_q    <= '0;
      out_sel_q   <= '0;
      out_rd_q    <= '0;
    end else begin
      regs_q      <= regs_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_i1_q    <= out_i1_d;
      out_i2_q    <= out_i2_d;
      out_sel_q   <= out_sel_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_i1    = out_i1_q;
  assign bus.out_i2    = out_i2_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb/tb_alu_operand_issue.sv - directed self-checking bench for alu_operand_issue
module tb_alu_operand_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef RF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  alu_operand_issue_if #(.DATA_W(32)) bus ();

  alu_operand_issue #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic imm_sel, input logic [10:0] imm);
    return {op, rd, rs, rt, imm_sel, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    cyc();
    bus.wb_en = 1'b0;
  endtask

  // Presents an instruction and waits (bounded) for it to be accepted
  task automatic issue(input logic [31:0] instr);
    int n;
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) begin
      check("issue_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Reader blocked on pending register a, released by writeback of d
  task automatic stall_then_wb(input logic [31:0] instr, input logic [4:0] a, input logic [31:0] d);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    #1;
    check("stall_c0_ready", {31'd0, bus.in_ready}, 32'd0);
    cyc();
    check("stall_c1_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    #1;
    check("wb_cycle_ready", {31'd0, bus.in_ready}, {31'd0, BYP});
    cyc();
    bus.wb_en = 1'b0;
`ifndef RF_BYPASS_EN
    #1;
    check("post_wb_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
`endif
    bus.in_valid = 1'b0;
    check("fwd_valid", {31'd0, bus.out_valid}, 32'd1);
    check("fwd_i1", bus.out_i1, d);
  endtask

  logic [31:0] vec [3];
  logic [4:0]  vsel [3];
  logic [31:0] vi1 [3];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b1;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_i1", bus.out_i1, 32'd0);
    check("rst_i2", bus.out_i2, 32'd0);
    check("rst_sel", {27'd0, bus.out_sel}, 32'd0);
    check("rst_rd", {27'd0, bus.out_rd}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic register-register issue
    wb(5'd3, 32'h0000_0010);
    wb(5'd4, 32'h1234_5678);
    issue(mk(5'b10000, 5'd5, 5'd3, 5'd4, 1'b0, 11'd0));
    check("rr_valid", {31'd0, bus.out_valid}, 32'd1);
    check("rr_i1", bus.out_i1, 32'h0000_0010);
    check("rr_i2", bus.out_i2, 32'h1234_5678);
    check("rr_sel", {27'd0, bus.out_sel}, 32'h10);
    check("rr_rd", {27'd0, bus.out_rd}, 32'd5);
    cyc();
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Immediate sign extension and r0 reads
    issue(mk(5'd1, 5'd0, 5'd0, 5'd0, 1'b1, 11'h7FF));
    check("imm_neg_i2", bus.out_i2, 32'hFFFF_FFFF);
    check("r0_i1", bus.out_i1, 32'd0);
    issue(mk(5'd1, 5'd0, 5'd0, 5'd0, 1'b1, 11'h3FF));
    check("imm_pos_i2", bus.out_i2, 32'h0000_03FF);

    // RAW hazard on r6
    issue(mk(5'd2, 5'd6, 5'd0, 5'd0, 1'b1, 11'd1));
    stall_then_wb(mk(5'd2, 5'd8, 5'd6, 5'd0, 1'b1, 11'd0), 5'd6, 32'h0000_CAFE);

    // Backpressure hold, then back-to-back stream
    issue(mk(5'd3, 5'd9, 5'd3, 5'd4, 1'b0, 11'd0));
    bus.out_ready = 1'b0;
    vec[0] = mk(5'd4, 5'd10, 5'd3, 5'd0, 1'b1, 11'd2);
    vec[1] = mk(5'd5, 5'd11, 5'd4, 5'd3, 1'b0, 11'd0);
    vec[2] = mk(5'd6, 5'd12, 5'd3, 5'd0, 1'b1, 11'd3);
    vsel[0] = 5'd4; vsel[1] = 5'd5; vsel[2] = 5'd6;
    vi1[0] = 32'h10; vi1[1] = 32'h1234_5678; vi1[2] = 32'h10;
    bus.in_instr = vec[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("hold_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_sel", {27'd0, bus.out_sel}, 32'd3);
      check("hold_i1", bus.out_i1, 32'h10);
      check("hold_i2", bus.out_i2, 32'h1234_5678);
      check("hold_rd", {27'd0, bus.out_rd}, 32'd9);
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.in_instr = vec[j];
      bus.in_valid = 1'b1;
      #1;
      check("stream_ready", {31'd0, bus.in_ready}, 32'd1);
      cyc();
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_sel", {27'd0, bus.out_sel}, {27'd0, vsel[j]});
      check("stream_i1", bus.out_i1, vi1[j]);
    end
    bus.in_valid = 1'b0;
    cyc();
    check("stream_drain", {31'd0, bus.out_valid}, 32'd0);

    // Same-cycle set and clear on r7: set wins
    bus.in_instr = mk(5'd8, 5'd7, 5'd3, 5'd0, 1'b1, 11'd0);
    bus.in_valid = 1'b1;
    bus.wb_en = 1'b1;
    bus.wb_addr = 5'd7;
    bus.wb_data = 32'h77;
    #1;
    check("setclr_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b0;
    stall_then_wb(mk(5'd9, 5'd13, 5'd7, 5'd0, 1'b0, 11'd0), 5'd7, 32'h99);
    check("r7_rt0_i2", bus.out_i2, 32'd0);

    // Reset in the middle of a stall with pending bits set
    bus.out_ready = 1'b0;
    bus.in_instr = mk(5'd10, 5'd14, 5'd9, 5'd0, 1'b1, 11'd0);
    bus.in_valid = 1'b1;
    #1;
    check("prerst_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_sel", {27'd0, bus.out_sel}, 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    issue(mk(5'd10, 5'd14, 5'd9, 5'd4, 1'b0, 11'd0));
    check("postrst_valid", {31'd0, bus.out_valid}, 32'd1);
    check("postrst_i1", bus.out_i1, 32'd0);
    check("postrst_i2", bus.out_i2, 32'd0);
    check("postrst_sel", {27'd0, bus.out_sel}, 32'd10);
    issue(mk(5'd11, 5'd0, 5'd3, 5'd7, 1'b0, 11'd0));
    check("postrst_r3", bus.out_i1, 32'd0);
    check("postrst_r7", bus.out_i2, 32'd0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
